control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute/writeback sequencer directly upstream of the 8x8 register file.
//  Fetches 16-bit instructions from a sync-read instruction memory and drives register-file ports:
//  read_reg1/2, write_reg, write_enable, write_data. Also drives the ALU opcode and owns the PC.
//  Sequential, one instruction in flight, no hazards.
// PARAMETERS
//  PC_WIDTH        8   instruction address width; PC wraps modulo 2^PC_WIDTH
//  DATA_WIDTH      8   register/ALU data width
//  REG_ADDR_WIDTH  3   register-file address width (8 registers)
//  RESET_PC        0   PC value loaded on reset
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               synchronous, active-high
//  instr_addr    out  PC_WIDTH        instruction memory address; data returns one cycle later
//  instr_data    in   16              instruction word for the previous cycle's instr_addr
//  read_reg1     out  REG_ADDR_WIDTH  register-file read port 1 address
//  read_reg2     out  REG_ADDR_WIDTH  register-file read port 2 address
//  read_data1    in   DATA_WIDTH      combinational read data, port 1
//  read_data2    in   DATA_WIDTH      combinational read data, port 2
//  alu_op        out  3               0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A
//  alu_result    in   DATA_WIDTH      combinational ALU result of read_data1/read_data2
//  write_reg     out  REG_ADDR_WIDTH  register-file write address
//  write_enable  out  1               register-file write strobe; high only in WRITEBACK
//  write_data    out  DATA_WIDTH      register-file write data
//  halted        out  1               high once HALT has executed
// BEHAVIOUR
//  Encoding: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0].
//  Opcodes:
//   0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd <= rs1 op rs2)
//   6 LDI rd <= imm8; 7 MOV rd <= rs1 (PASS_A)
//   8 JMP pc <= imm8; 9 BZ: if reg[rd]==0 then pc <= imm8 (rd field is the source here)
//   F HALT; A-E are executed as NOP
//  FSM states: FETCH -> DECODE -> EXEC -> [WB] -> FETCH; HALT is terminal.
//   FETCH : instr_addr=pc.
//   DECODE: ir <= instr_data; pc <= pc+1, wrapping 0xFF -> 0x00.
//   EXEC  : read_reg1=rs1 (rd for BZ), read_reg2=rs2; alu_op decoded.
//           result <= alu_result, or imm8 for LDI.
//           JMP/taken BZ: pc <= imm8. HALT -> HALT state.
//           Opcodes 1-7 go to WB; all others go to FETCH.
//   WB    : write_enable=1, write_reg=rd, write_data=result; register file captures at the WB edge.
//   HALT  : held until reset; halted=1; write_enable=0.
//  Cycle counts: 4 cycles for 1-7; 3 cycles for NOP/JMP/BZ/illegal.
//  The next instruction's EXEC read of a just-written rd sees the new value (two edges later).
//  read_reg*/write_reg/alu_op derive from ir; ir resets to 0, so these ports are 0 after reset.
//  Reset values: state=FETCH, pc=RESET_PC, instr_addr=RESET_PC, ir=0, result=0,
//   write_enable=0, write_data=0, write_reg=0, read_reg1/2=0, alu_op=0, halted=0.
//  Reset asserted in any state, including WB: write_enable=0 from the next edge; no partial write persists.
//  Reset while HALTed: halted=0, fetch restarts at RESET_PC.
//  write_enable is never high outside WB.
// STRUCTURE
//  Shared include cpu_defines.vh: opcode localparams, alu_op codes, instruction field positions.
//  FSM state encoding stays local.
//  One combinational sub-module instr_decoder: ir -> rd/rs1/rs2/imm8/alu_op/writes_rd/is_jmp/is_bz/is_halt.
// TESTING
//  Bench models a sync-read imem and the 8x8 register file.
//  1. Reset, then LDI r1,0x0D; LDI r2,0x03; ADD r3,r1,r2
//     -> r3=0x10; write_enable pulses exactly once per LDI/ADD, each in cycle 4 of its instruction.
//  2. SUB r4,r2,r1 (0x03-0x0D) -> r4=0xF6 (8-bit wrap); XOR r5,r1,r1 -> r5=0x00.
//  3. BZ r5,0x20 with r5=0 -> next instr_addr=0x20; BZ r1,0x40 with r1=0x0D -> falls through to pc+1.
//  4. JMP 0xFF; NOP at 0xFF -> following fetch at 0x00 (PC wrap).
//  5. HALT -> halted=1 within 3 cycles; instr_addr frozen and write_enable=0 for 20 cycles.
//     Reset -> halted=0, fetch at 0x00.
//  6. Assert reset during WB of ADD -> write_enable=0 on the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes and
// instruction field positions.
package control_sequencer_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_A = 3'd5;

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// register fields, immediate, ALU operation and control flags.
module control_sequencer_instr_decoder
    import control_sequencer_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir_i,
    output logic [2:0]             rd_o,
    output logic [2:0]             rs1_o,
    output logic [2:0]             rs2_o,
    output logic [7:0]             imm8_o,
    output logic [2:0]             alu_op_o,
    output logic                   writes_rd_o,
    output logic                   is_ldi_o,
    output logic                   is_jmp_o,
    output logic                   is_bz_o,
    output logic                   is_halt_o
);

    logic [3:0] op;

    assign op     = ir_i[OP_MSB:OP_LSB];
    assign rd_o   = ir_i[RD_MSB:RD_LSB];
    assign rs1_o  = ir_i[RS1_MSB:RS1_LSB];
    assign rs2_o  = ir_i[RS2_MSB:RS2_LSB];
    assign imm8_o = ir_i[IMM_MSB:IMM_LSB];

    always_comb begin
        alu_op_o    = ALU_ADD;
        writes_rd_o = 1'b0;
        is_ldi_o    = 1'b0;
        is_jmp_o    = 1'b0;
        is_bz_o     = 1'b0;
        is_halt_o   = 1'b0;
        case (op)
            OP_ADD: begin alu_op_o = ALU_ADD;    writes_rd_o = 1'b1; end
            OP_SUB: begin alu_op_o = ALU_SUB;    writes_rd_o = 1'b1; end
            OP_AND: begin alu_op_o = ALU_AND;    writes_rd_o = 1'b1; end
            OP_OR:  begin alu_op_o = ALU_OR;     writes_rd_o = 1'b1; end
            OP_XOR: begin alu_op_o = ALU_XOR;    writes_rd_o = 1'b1; end
            OP_LDI: begin is_ldi_o = 1'b1;       writes_rd_o = 1'b1; end
            OP_MOV: begin alu_op_o = ALU_PASS_A; writes_rd_o = 1'b1; end
            OP_JMP:  is_jmp_o  = 1'b1;
            OP_BZ:   is_bz_o   = 1'b1;
            OP_HALT: is_halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the
// register file, ALU opcode and instruction memory address.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int PC_WIDTH       = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int RESET_PC       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [PC_WIDTH-1:0]       instr_addr,
    input  logic [INSTR_WIDTH-1:0]    instr_data,
    output logic [REG_ADDR_WIDTH-1:0] read_reg1,
    output logic [REG_ADDR_WIDTH-1:0] read_reg2,
    input  logic [DATA_WIDTH-1:0]     read_data1,
    input  logic [DATA_WIDTH-1:0]     read_data2,
    output logic [2:0]                alu_op,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic                      write_enable,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;

    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm8;
    logic       writes_rd, is_ldi, is_jmp, is_bz, is_halt;
    logic       unused_rd2;

    // Operand 2 only feeds the external ALU; the sequencer never inspects it.
    assign unused_rd2 = ^read_data2;

    control_sequencer_instr_decoder u_dec (
        .ir_i        (ir_q),
        .rd_o        (rd),
        .rs1_o       (rs1),
        .rs2_o       (rs2),
        .imm8_o      (imm8),
        .alu_op_o    (alu_op),
        .writes_rd_o (writes_rd),
        .is_ldi_o    (is_ldi),
        .is_jmp_o    (is_jmp),
        .is_bz_o     (is_bz),
        .is_halt_o   (is_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_WIDTH'(RESET_PC);
            ir_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr_data;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = is_ldi ? DATA_WIDTH'(imm8) : alu_result;
                // BZ tests the register named by rd, routed through port 1.
                if (is_jmp || (is_bz && read_data1 == '0)) begin
                    pc_d = PC_WIDTH'(imm8);
                end
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (writes_rd) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    assign instr_addr   = pc_q;
    assign read_reg1    = REG_ADDR_WIDTH'(is_bz ? rd : rs1);
    assign read_reg2    = REG_ADDR_WIDTH'(rs2);
    assign write_reg    = REG_ADDR_WIDTH'(rd);
    assign write_data   = result_q;
    assign write_enable = (state_q == S_WB);
    assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: sync-read imem, 8x8 register file and ALU around the
// sequencer, with an instruction-level reference model checked every cycle.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [2:0]  read_reg1, read_reg2, write_reg, alu_op;
    logic [7:0]  read_data1, read_data2, alu_result, write_data;
    logic        write_enable, halted;

    logic [15:0] imem [256];
    logic [7:0]  rf [8];
    logic        rf_clr = 1'b0;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr_addr   (instr_addr),
        .instr_data   (instr_data),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .write_reg    (write_reg),
        .write_enable (write_enable),
        .write_data   (write_data),
        .halted       (halted)
    );

    always @(posedge clk) instr_data <= imem[instr_addr];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (write_enable) begin
            rf[write_reg] <= write_data;
        end
    end

    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'd0: alu_result = read_data1 + read_data2;
            3'd1: alu_result = read_data1 - read_data2;
            3'd2: alu_result = read_data1 & read_data2;
            3'd3: alu_result = read_data1 | read_data2;
            3'd4: alu_result = read_data1 ^ read_data2;
            3'd5: alu_result = read_data1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Instruction-level model: one instruction at a time, its cycle length,
    // its single writeback and its successor PC.
    logic [7:0]  m_regs [8];
    logic [7:0]  m_pc, m_next, m_val, m_a, m_b, m_imm;
    logic [15:0] m_ins;
    logic [3:0]  m_op;
    logic [2:0]  m_rd;
    logic        m_wr, m_stop, m_halt;
    int          m_k, m_len;

    always @(negedge clk) begin
        if (reset) begin
            m_pc   = 8'h00;
            m_k    = 0;
            m_halt = 1'b0;
            for (int i = 0; i < 8; i++) m_regs[i] = rf[i];
        end else if (chk_en) begin
            if (m_halt) begin
                chk("halt_flag", int'(halted), 1);
                chk("halt_we", int'(write_enable), 0);
                chk("halt_addr", int'(instr_addr), int'(m_pc));
            end else begin
                if (m_k == 0) begin
                    m_ins  = imem[m_pc];
                    m_op   = m_ins[15:12];
                    m_rd   = m_ins[11:9];
                    m_a    = m_regs[m_ins[8:6]];
                    m_b    = m_regs[m_ins[5:3]];
                    m_imm  = m_ins[7:0];
                    m_next = m_pc + 8'd1;
                    m_wr   = (m_op >= 4'd1 && m_op <= 4'd7);
                    m_stop = (m_op == 4'hF);
                    m_val  = 8'h00;
                    case (m_op)
                        4'd1: m_val = m_a + m_b;
                        4'd2: m_val = m_a - m_b;
                        4'd3: m_val = m_a & m_b;
                        4'd4: m_val = m_a | m_b;
                        4'd5: m_val = m_a ^ m_b;
                        4'd6: m_val = m_imm;
                        4'd7: m_val = m_a;
                        4'd8: m_next = m_imm;
                        4'd9: if (m_regs[m_rd] == 8'h00) m_next = m_imm;
                        default: ;
                    endcase
                    m_len = m_wr ? 4 : 3;
                    chk("fetch_addr", int'(instr_addr), int'(m_pc));
                end
                chk("halted_run", int'(halted), 0);
                chk("we", int'(write_enable), int'(m_wr && m_k == 3));
                if (m_wr && m_k == 3) begin
                    chk("wb_reg", int'(write_reg), int'(m_rd));
                    chk("wb_data", int'(write_data), int'(m_val));
                end
                m_k++;
                if (m_k == m_len) begin
                    if (m_wr) m_regs[m_rd] = m_val;
                    m_pc   = m_next;
                    m_halt = m_stop;
                    m_k    = 0;
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, int'(instr_addr), 0);
        chk({tag, "_rr1"}, int'(read_reg1), 0);
        chk({tag, "_rr2"}, int'(read_reg2), 0);
        chk({tag, "_aluop"}, int'(alu_op), 0);
        chk({tag, "_wreg"}, int'(write_reg), 0);
        chk({tag, "_we"}, int'(write_enable), 0);
        chk({tag, "_wdata"}, int'(write_data), 0);
        chk({tag, "_halted"}, int'(halted), 0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        rf_clr = 1'b1;
        @(posedge clk);
        #1 rf_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    logic [7:0] trace [64];
    int n, k, we_cnt, first_we;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
        imem[8'h00] = 16'h9C10;
        imem[8'h10] = 16'h6C01;
        imem[8'h11] = 16'h80FF;
        imem[8'hFF] = 16'h0000;
        imem[8'h01] = 16'h620D;
        imem[8'h02] = 16'h6403;
        imem[8'h03] = 16'h1650;
        imem[8'h04] = 16'h2888;
        imem[8'h05] = 16'h5A48;
        imem[8'h06] = 16'h9A20;
        imem[8'h20] = 16'h9240;
        imem[8'h21] = 16'hF000;

        do_reset();
        n = 0;
        we_cnt = 0;
        first_we = -1;
        @(negedge clk);
        while (halted !== 1'b1 && n < 200) begin
            if (n < 64) trace[n] = instr_addr;
            if (write_enable) begin
                we_cnt++;
                if (first_we < 0) first_we = n;
            end
            n++;
            @(negedge clk);
        end
        chk("halt_cycle", n, 45);
        chk("we_pulses", we_cnt, 6);
        chk("first_we_cycle", first_we, 6);
        chk("addr_jmp_ff", int'(trace[10]), 'hFF);
        chk("addr_wrap_00", int'(trace[13]), 'h00);
        chk("addr_bz_taken", int'(trace[39]), 'h20);
        chk("addr_bz_fall", int'(trace[42]), 'h21);
        chk("r1", int'(rf[1]), 'h0D);
        chk("r3_add", int'(rf[3]), 'h10);
        chk("r4_sub_wrap", int'(rf[4]), 'hF6);
        chk("r5_xor", int'(rf[5]), 'h00);
        chk("r6", int'(rf[6]), 'h01);
        for (int c = 0; c < 20; c++) begin
            chk("hold_addr", int'(instr_addr), 'h22);
            chk("hold_we", int'(write_enable), 0);
            @(negedge clk);
        end

        do_reset();
        @(negedge clk);
        chk("restart_halted", int'(halted), 0);
        chk("restart_addr", int'(instr_addr), 0);

        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
        imem[0] = 16'h620D;
        imem[1] = 16'h6403;
        imem[2] = 16'h1650;
        do_reset();
        k = 0;
        @(negedge clk);
        while (!(write_enable && write_reg == 3'd3) && k < 60) begin
            k++;
            @(negedge clk);
        end
        chk("wb_seen", int'(write_enable && write_reg == 3'd3), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("wbrst");

        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 256; a++) imem[a] = 16'($urandom);
            do_reset();
            n = 0;
            while (halted !== 1'b1 && n < 1500) begin
                @(negedge clk);
                n++;
            end
            if (halted) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    chk("rand_reg", int'(rf[i]), int'(m_regs[i]));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
